uart_mem_loader: RTL and testbench
==================================

# uart_mem_loader

Serial program loader that receives 8N1 UART bytes, pairs them into 16-bit words (high byte first), and writes them into consecutive RAM addresses starting at 0x0000. It is the write-side counterpart of the memory-dump path. The top level muxes its `mem_we`/`mem_addr`/`mem_din` onto the RAM port while `load_en` is high, which lets a program be downloaded to the RISC_16 memory without resynthesis.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- CLKS_PER_BIT is derived, not overridable: CLK_HZ/BAUD, integer division (868 at the defaults).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- rx  in  1  UART serial input, idle high, asynchronous to clk.
- load_en  in  1  level; loader owns the RAM port while high.
- mem_we  out  1  RAM write strobe, one clk wide.
- mem_addr  out  16  RAM write address (the write pointer).
- mem_din  out  16  RAM write data.
- word_count  out  16  words written since the last load_en rise; saturates at 0xFFFF.
- busy  out  1  high when the receiver is not IDLE or a high byte is pending.
- frame_err  out  1  sticky framing-error flag.

## Operation
- Synchronization: rx passes through 2 flops (`rx_s`); all decisions use `rx_s`. The flops reset to 1.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE -> START when `rx_s`=0. The bit timer is loaded with CLKS_PER_BIT/2.
- START: when the timer expires, sample `rx_s`.
  - `rx_s`=0: go to DATA and reload the timer with CLKS_PER_BIT.
  - `rx_s`=1: glitch; return to IDLE with no other effect.
- DATA: sample 8 bits, LSB first, each one CLKS_PER_BIT after the previous sample, then go to STOP.
- STOP: sample after CLKS_PER_BIT.
  - `rx_s`=1: byte valid; go to IDLE.
  - `rx_s`=0: set frame_err, discard the byte, clear the byte phase to HI, go to WAIT_IDLE.
- WAIT_IDLE -> IDLE once `rx_s`=1.
- Word assembly (only while load_en=1):
  - A valid byte with phase HI is stored in `hi_reg`; phase becomes LO.
  - A valid byte with phase LO triggers a write:
    - mem_din <= {hi_reg, byte}.
    - mem_we pulses for 1 cycle at the current mem_addr.
    - The cycle after the pulse, mem_addr increments.
    - word_count increments unless it is 0xFFFF.
    - Phase returns to HI.
- Bytes completed while load_en=0 are discarded. The RX FSM still runs.
- load_en rising edge (registered compare): mem_addr<=0, word_count<=0, phase<=HI, frame_err<=0.
  - An in-flight RX frame continues; its byte counts as a HI byte.
- load_en falling edge: phase<=HI. A pending high byte is dropped. mem_addr and word_count hold.
- mem_addr wraps from 0xFFFF to 0x0000.
- frame_err clears only on reset or a load_en rise.
- Reset mid-frame: FSM goes to IDLE and every output returns to its reset value immediately.

## Timing
- Reset values: mem_we=0, mem_addr=0x0000, mem_din=0x0000, word_count=0, busy=0, frame_err=0.
- Input latency: 2 cycles of synchronizer delay from a pin change to `rx_s`.
- Byte-valid pulse: the cycle after the STOP sample.
- mem_we: asserted the cycle after the byte-valid of the low byte. mem_din and mem_addr are stable for the whole mem_we cycle.
- mem_addr update: the cycle after mem_we; word_count updates in the same cycle as mem_addr.
- frame_err: rises the cycle after a bad STOP sample.
- Throughput: one word per 20 bit times.
- Back-to-back frames are accepted: the next start bit may begin immediately after the stop bit.

## Test plan
Sims use CLK_HZ=1_000_000 and BAUD=100_000, so CLKS_PER_BIT=10.
1. Reset, then load_en=1, then send bytes 0x12,0x34 -> exactly one mem_we pulse with mem_addr=0x0000 and mem_din=0x1234; afterwards mem_addr=1, word_count=1, busy=0.
2. Send 6 back-to-back bytes 0xAB,0xCD,0x00,0x01,0xFF,0xFF -> writes 0xABCD@0, 0x0001@1, 0xFFFF@2; word_count=3; no gaps dropped.
3. Send a frame with the stop bit forced to 0, then 0x56,0x78 -> frame_err=1 and no write for the bad byte; next write is 0x5678@0. Toggling load_en 0->1 clears frame_err.
4. Send a 3-clock low glitch on rx -> no byte accepted, FSM back in IDLE, frame_err=0.
5. Send 0x11, drop load_en, raise it, send 0x22,0x33 -> single write 0x2233@0; the 0x11 is discarded.
6. Force mem_addr to 0xFFFF (preload via 65535 words or a backdoor), then send one word -> write@0xFFFF and mem_addr wraps to 0x0000. Assert reset mid-DATA -> all outputs return to their reset values and the next clean word writes @0.

Source files
------------

// File: rtl/uart_mem_loader.sv
// UART program loader: receives 8N1 bytes, pairs them high-byte-first into
// 16-bit words and writes them to consecutive RAM addresses from 0x0000.
module uart_mem_loader #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        load_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [15:0] word_count,
    output logic        busy,
    output logic        frame_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned TW           = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_e;

    // Byte phase: HI means the next valid byte is the high half of a word.
    localparam logic PH_HI = 1'b0;
    localparam logic PH_LO = 1'b1;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    hi_q, hi_d;
    logic          phase_q, phase_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          mem_we_q, mem_we_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic [15:0]   mem_din_q, mem_din_d;
    logic [15:0]   word_count_q, word_count_d;
    logic          busy_q, busy_d;
    logic          load_en_q;
    logic          rx_meta_q, rx_s_q;
    logic          tick;

    // Two-flop synchronizer for the asynchronous serial input, idle high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            hi_q         <= '0;
            phase_q      <= PH_HI;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            word_count_q <= '0;
            busy_q       <= 1'b0;
            load_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            hi_q         <= hi_d;
            phase_q      <= phase_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            word_count_q <= word_count_d;
            busy_q       <= busy_d;
            load_en_q    <= load_en;
        end
    end

    assign tick = (timer_q <= TW'(1));

    // RX FSM, word assembly and load_en edge handling.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        hi_d         = hi_q;
        phase_d      = phase_q;
        byte_valid_d = 1'b0;
        frame_err_d  = frame_err_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        word_count_d = word_count_q;

        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    timer_d = TW'(HALF_BIT);
                end
            end
            START: begin
                if (!tick) begin
                    timer_d = TW'(timer_q - TW'(1));
                end else if (!rx_s_q) begin
                    state_d   = DATA;
                    timer_d   = TW'(CLKS_PER_BIT);
                    bit_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!tick) begin
                    timer_d = TW'(timer_q - TW'(1));
                end else begin
                    shreg_d   = {rx_s_q, shreg_q[7:1]};
                    timer_d   = TW'(CLKS_PER_BIT);
                    bit_cnt_d = 3'(bit_cnt_q + 3'd1);
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (!tick) begin
                    timer_d = TW'(timer_q - TW'(1));
                end else if (rx_s_q) begin
                    byte_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    phase_d     = PH_HI;
                    state_d     = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pointer advances the cycle after the write strobe.
        if (mem_we_q) begin
            mem_addr_d = 16'(mem_addr_q + 16'd1);
            if (word_count_q != 16'hFFFF) begin
                word_count_d = 16'(word_count_q + 16'd1);
            end
        end

        if (byte_valid_q && load_en) begin
            if (phase_q == PH_HI) begin
                hi_d    = shreg_q;
                phase_d = PH_LO;
            end else begin
                mem_din_d = {hi_q, shreg_q};
                mem_we_d  = 1'b1;
                phase_d   = PH_HI;
            end
        end

        // A new load session restarts the pointer; a byte landing now is a HI byte.
        if (load_en && !load_en_q) begin
            mem_addr_d   = '0;
            word_count_d = '0;
            frame_err_d  = 1'b0;
            mem_we_d     = 1'b0;
            phase_d      = PH_HI;
            if (byte_valid_q) begin
                hi_d    = shreg_q;
                phase_d = PH_LO;
            end
        end

        if (!load_en && load_en_q) begin
            phase_d = PH_HI;
        end

        busy_d = (state_d != IDLE) || (phase_d == PH_LO);
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign word_count = word_count_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares each mem_we pulse.
module tb_uart_mem_loader;

    localparam int CPB = 10;

    logic        clk;
    logic        reset;
    logic        rx;
    logic        load_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] word_count;
    logic        busy;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    uart_mem_loader #(
        .CLK_HZ(1_000_000),
        .BAUD  (100_000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .load_en   (load_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .word_count(word_count),
        .busy      (busy),
        .frame_err (frame_err)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got 0x%04h@0x%04h expected no write", mem_din, mem_addr);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_din} !== e) begin
                    failures++;
                    $display("FAIL write: got 0x%04h@0x%04h expected 0x%04h@0x%04h",
                             mem_din, mem_addr, e[15:0], e[31:16]);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop_bit;
        idle(CPB);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [15:0] addr, input logic [15:0] data);
        exp_q.push_back({addr, data});
        send_byte(data[15:8], 1'b1);
        send_byte(data[7:0], 1'b1);
    endtask

    task automatic toggle_load;
        load_en = 1'b0;
        idle(2);
        load_en = 1'b1;
        idle(2);
    endtask

    initial begin
        reset   = 1'b1;
        rx      = 1'b1;
        load_en = 1'b0;
        idle(4);
        #1;
        check16("rst_mem_we", 16'(mem_we), 16'h0);
        check16("rst_mem_addr", mem_addr, 16'h0000);
        check16("rst_mem_din", mem_din, 16'h0000);
        check16("rst_word_count", word_count, 16'h0000);
        check16("rst_busy", 16'(busy), 16'h0);
        check16("rst_frame_err", 16'(frame_err), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // 1: single word.
        load_en = 1'b1;
        idle(2);
        send_word(16'h0000, 16'h1234);
        idle(20);
        check16("t1_mem_addr", mem_addr, 16'h0001);
        check16("t1_word_count", word_count, 16'h0001);
        check16("t1_busy", 16'(busy), 16'h0);

        // 2: six back-to-back bytes.
        toggle_load();
        exp_q.push_back({16'h0000, 16'hABCD});
        exp_q.push_back({16'h0001, 16'h0001});
        exp_q.push_back({16'h0002, 16'hFFFF});
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(20);
        check16("t2_word_count", word_count, 16'h0003);
        check16("t2_mem_addr", mem_addr, 16'h0003);

        // 3: framing error, then clean word.
        toggle_load();
        send_byte(8'hA5, 1'b0);
        idle(20);
        check16("t3_frame_err_set", 16'(frame_err), 16'h1);
        send_word(16'h0000, 16'h5678);
        idle(20);
        check16("t3_frame_err_sticky", 16'(frame_err), 16'h1);
        toggle_load();
        check16("t3_frame_err_clear", 16'(frame_err), 16'h0);

        // 4: short low glitch is rejected.
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(20);
        check16("t4_busy", 16'(busy), 16'h0);
        check16("t4_frame_err", 16'(frame_err), 16'h0);
        check16("t4_word_count", word_count, 16'h0000);
        send_word(16'h0000, 16'h9ABC);
        idle(20);

        // 5: pending high byte dropped across a load_en toggle.
        send_byte(8'h11, 1'b1);
        idle(10);
        toggle_load();
        send_word(16'h0000, 16'h2233);
        idle(20);
        check16("t5_word_count", word_count, 16'h0001);

        // 6: address wrap via backdoor preload.
        force dut.mem_addr_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.mem_addr_q;
        idle(2);
        check16("t6_preload", mem_addr, 16'hFFFF);
        send_word(16'hFFFF, 16'hBEEF);
        idle(20);
        check16("t6_wrap", mem_addr, 16'h0000);
        check16("t6_din", mem_din, 16'hBEEF);

        // 6b: reset in the middle of the data bits.
        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(CPB);
        rx = 1'b0;
        idle(CPB / 2);
        reset = 1'b1;
        #1;
        check16("mid_rst_mem_we", 16'(mem_we), 16'h0);
        check16("mid_rst_mem_addr", mem_addr, 16'h0000);
        check16("mid_rst_mem_din", mem_din, 16'h0000);
        check16("mid_rst_word_count", word_count, 16'h0000);
        check16("mid_rst_busy", 16'(busy), 16'h0);
        check16("mid_rst_frame_err", 16'(frame_err), 16'h0);
        rx = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(20);
        send_word(16'h0000, 16'h4321);
        idle(20);
        check16("post_rst_mem_addr", mem_addr, 16'h0001);

        check16("pending_writes", 16'(exp_q.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
